bram11_arb: RTL
===============

BRAM11_ARB -- requirements
Module: bram11_arb

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 12, byte-address width; DATA_W, default 32, word width; DEPTH, default 11, words in the attached RAM; MAX_BURST, default 11, maximum consecutive locked grants.
REQ-002 Ports SHALL be, in order:
- axis_clk  in  1  sole clock, rising edge.
- axis_rst_n  in  1  asynchronous active-low reset.
- m0_req / m1_req  in  1  access request; master 0 = AXI-Lite config, master 1 = FIR engine.
- mN_lock  in  1  keep ownership for the following cycle.
- mN_we  in  4  byte write enables; 0 means read.
- mN_addr  in  ADDR_W  byte address.
- mN_wdata  in  DATA_W  write data.
- mN_gnt  out  1  access accepted this cycle.
- mN_rvalid  out  1  read data valid.
- mN_rdata  out  DATA_W  read data.
- bram_EN  out  1  RAM enable.
- bram_WE  out  4  RAM byte enables.
- bram_A  out  ADDR_W  RAM byte address.
- bram_Di  out  DATA_W  RAM write data.
- bram_Do  in  DATA_W  RAM read data, valid the cycle after the address is presented.
- err  out  1  sticky out-of-range flag.

Function
REQ-003 The arbiter SHALL use three states: IDLE, OWN0, OWN1.
REQ-004 Grant SHALL be combinational: mN_gnt=1 in the same cycle as mN_req when master N wins; bram_EN/WE/A/Di SHALL carry the winner's fields in that cycle.
REQ-005 In IDLE with one request pending, that requester SHALL win.
REQ-006 In IDLE with both requests pending, the master not granted most recently SHALL win (round-robin); after reset, master 0 SHALL win.
REQ-007 A grant with mN_lock=1 SHALL move the arbiter to OWNn; otherwise it SHALL return to IDLE.
REQ-008 In OWNn, master n SHALL have absolute priority while mN_req=1.
- OWNn SHALL be left for IDLE when mN_req=0 or mN_lock=0.
- OWNn SHALL also be left when the burst counter reaches MAX_BURST consecutive grants; the other master SHALL then win the next cycle if it is requesting.
REQ-009 The burst counter SHALL:
- count grants within one ownership;
- be 4 bits wide;
- clear on every state change.
REQ-010 With no grant, bram_EN=0 and bram_WE=0; bram_A and bram_Di SHALL hold their last driven values.
REQ-011 A granted read (we=0) SHALL set mN_rvalid=1 exactly one cycle later, with mN_rdata=bram_Do in that cycle.
- The other master's rvalid SHALL be 0 in that cycle.
- mN_rdata SHALL hold its value while rvalid=0.
REQ-012 Back-to-back reads SHALL sustain one result per cycle; read latency SHALL be 1 cycle.
REQ-013 A granted write SHALL produce no rvalid.
REQ-014 Each requester SHALL hold req and its fields stable until gnt; an ungranted request SHALL stall without loss.
REQ-015 When both masters write the same word, accesses SHALL be serialised in grant order; the last-granted write wins.

Reset
REQ-016 Asserting axis_rst_n low SHALL asynchronously force:
- state=IDLE;
- last-granted=master 1, so master 0 wins first;
- burst counter=0;
- all rvalid=0, rdata=0;
- bram_EN=0, bram_WE=0, bram_A=0, bram_Di=0;
- err=0.
REQ-017 A read granted in the cycle reset asserts SHALL produce no rvalid after reset releases.

Configuration
REQ-018 Macro BRAM11_ARB_BOUNDS_CHK_EN defined: a granted access with (addr>>2) >= DEPTH SHALL:
- still assert gnt;
- drive bram_EN=0 and bram_WE=0;
- for a read, return rvalid with rdata=0;
- set err until reset.
REQ-019 Macro undefined: addresses SHALL pass through unchecked, and err SHALL be tied 0.

Structure
REQ-020 A shared package SHALL hold:
- the state enumeration (IDLE/OWN0/OWN1);
- the master-index type;
- the DEPTH and MAX_BURST defaults.
REQ-021 The round-robin/lock decision SHALL be one sub-module, bram11_arb_pick, a combinational function of requests, locks, state and last-granted; the parent SHALL hold all registers and muxes.

Verification
REQ-022 Single read: m1 reads addr 0x08 (RAM[2]=0x12345678). Required: gnt the same cycle, m1_rvalid=1 with rdata=0x12345678 next cycle.
REQ-023 Contention: m0 and m1 request together from reset. Required: m0 granted, then m1, then alternating while both stay requesting.
REQ-024 Burst cap: m1 locked with continuous reads and m0 requesting throughout. Required: exactly 11 m1 grants, then an m0 grant.
REQ-025 Byte write: m0 writes we=0x2, wdata=0xAABBCCDD to 0x04 over 0x00000000, then reads 0x04. Required: rdata=0x0000CC00.
REQ-026 Mid-burst reset: reset asserted during locked m1 reads. Required: immediate IDLE, no stray rvalid, m0 first winner after release.
REQ-027 Bounds (macro on): read 0x2C (word 11). Required: bram_EN=0, rvalid with rdata=0, err=1 and sticky. Macro off: bram_EN=1 and err=0.

Source files
------------

// File: rtl/bram11_arb_pkg.sv
// Shared types and default sizes for the two-master BRAM arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
//
// Holds the arbiter state encoding, the master index type and the default
// RAM depth and burst cap used by bram11_arb and bram11_arb_pick.
package bram11_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Master 0 is the AXI-Lite config port, master 1 the FIR engine.
  typedef logic mst_idx_t;

  localparam mst_idx_t MST0 = 1'b0;
  localparam mst_idx_t MST1 = 1'b1;

  localparam int DEPTH_DEF     = 11;
  localparam int MAX_BURST_DEF = 11;
  localparam int BURST_W       = 4;

endpackage

// File: rtl/bram11_arb_pick.sv
// Round-robin / lock winner selection for the two BRAM masters.
// Latency: purely combinational, decision valid in the request cycle.
// Backpressure: a losing master simply sees no grant and keeps requesting.
//
// Ports: req0_i/req1_i, lock0_i/lock1_i  master requests and lock hints
//        state_i, last_i, burst_last_i  current owner state, last winner,
//                                        "this grant completes the burst"
//        gnt0_o/gnt1_o, state_d_o       winner and next arbiter state
module bram11_arb_pick
  import bram11_arb_pkg::*;
(
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       lock0_i,
  input  logic       lock1_i,
  input  arb_state_e state_i,
  input  mst_idx_t   last_i,
  input  logic       burst_last_i,
  output logic       gnt0_o,
  output logic       gnt1_o,
  output arb_state_e state_d_o
);

  logic       rr0;
  logic       rr1;
  arb_state_e rr_state;

  // Open arbitration: a lone requester wins, a tie goes to whoever did not
  // win last time.
  always_comb begin
    rr0      = req0_i && (!req1_i || (last_i == MST1));
    rr1      = req1_i && (!req0_i || (last_i == MST0));
    rr_state = ST_IDLE;
    if (rr0 && lock0_i) begin
      rr_state = ST_OWN0;
    end else if (rr1 && lock1_i) begin
      rr_state = ST_OWN1;
    end
  end

  // An owner keeps absolute priority while it requests. When it drops its
  // request the slot is arbitrated openly the same cycle so the other master
  // does not lose a cycle. The grant that completes the burst forces IDLE,
  // which hands the next tie to the other master.
  always_comb begin
    gnt0_o    = 1'b0;
    gnt1_o    = 1'b0;
    state_d_o = ST_IDLE;
    case (state_i)
      ST_OWN0: begin
        if (req0_i) begin
          gnt0_o = 1'b1;
          if (lock0_i && !burst_last_i) state_d_o = ST_OWN0;
        end else begin
          gnt0_o    = rr0;
          gnt1_o    = rr1;
          state_d_o = rr_state;
        end
      end
      ST_OWN1: begin
        if (req1_i) begin
          gnt1_o = 1'b1;
          if (lock1_i && !burst_last_i) state_d_o = ST_OWN1;
        end else begin
          gnt0_o    = rr0;
          gnt1_o    = rr1;
          state_d_o = rr_state;
        end
      end
      default: begin
        gnt0_o    = rr0;
        gnt1_o    = rr1;
        state_d_o = rr_state;
      end
    endcase
  end

endmodule

// File: rtl/bram11_arb.sv
// Two-master arbiter in front of a single-port BRAM with 1-cycle read data.
// Latency: grant and RAM strobes combinational; read data 1 cycle after grant.
// Backpressure: an ungranted request stalls (req and fields held) until gnt.
//
// Ports: axis_clk/axis_rst_n  clock, async active-low reset
//        mN_req/lock/we/addr/wdata -> mN_gnt/rvalid/rdata  per-master access
//        bram_EN/WE/A/Di/Do  RAM port; err  sticky out-of-range flag
// Optional: BRAM11_ARB_BOUNDS_CHK_EN enables word-index range checking
// against DEPTH (out-of-range accesses are granted but kept off the RAM).
// MAX_BURST must be at least 2.
module bram11_arb
  import bram11_arb_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_lock,
  input  logic              m1_lock,
  input  logic [3:0]        m0_we,
  input  logic [3:0]        m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bram_EN,
  output logic [3:0]        bram_WE,
  output logic [ADDR_W-1:0] bram_A,
  output logic [DATA_W-1:0] bram_Di,
  input  logic [DATA_W-1:0] bram_Do,
  output logic              err
);

  // The counter only counts grants made while already in OWNn; the grant
  // that entered OWNn was made from IDLE. So MAX_BURST consecutive grants
  // are complete when the OWN-state count reaches MAX_BURST-2.
  localparam logic [BURST_W-1:0] BURST_LAST_CNT = BURST_W'(MAX_BURST - 2);

  arb_state_e         state_q;
  arb_state_e         state_d;
  mst_idx_t           last_q;
  logic [BURST_W-1:0] cnt_q;
  logic [BURST_W-1:0] cnt_d;
  logic               burst_last;

  logic               pick_gnt0;
  logic               pick_gnt1;
  logic               gnt0;
  logic               gnt1;
  logic               any_gnt;
  logic               oob;
  logic               acc_en;

  logic [3:0]         win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;

  logic               rvalid0_q;
  logic               rvalid1_q;
  logic [DATA_W-1:0]  rhold0_q;
  logic [DATA_W-1:0]  rhold1_q;
  logic [DATA_W-1:0]  rd_word;
  logic [ADDR_W-1:0]  a_q;
  logic [DATA_W-1:0]  di_q;

  assign burst_last = (state_q != ST_IDLE) && (cnt_q == BURST_LAST_CNT);

  bram11_arb_pick u_pick (
    .req0_i       (m0_req),
    .req1_i       (m1_req),
    .lock0_i      (m0_lock),
    .lock1_i      (m1_lock),
    .state_i      (state_q),
    .last_i       (last_q),
    .burst_last_i (burst_last),
    .gnt0_o       (pick_gnt0),
    .gnt1_o       (pick_gnt1),
    .state_d_o    (state_d)
  );

  // Grants are combinational from req, so they are gated by reset to keep
  // the RAM port quiet while reset is held.
  assign gnt0    = pick_gnt0 & axis_rst_n;
  assign gnt1    = pick_gnt1 & axis_rst_n;
  assign any_gnt = gnt0 | gnt1;
  assign m0_gnt  = gnt0;
  assign m1_gnt  = gnt1;

  assign win_we    = gnt1 ? m1_we    : m0_we;
  assign win_addr  = gnt1 ? m1_addr  : m0_addr;
  assign win_wdata = gnt1 ? m1_wdata : m0_wdata;

`ifdef BRAM11_ARB_BOUNDS_CHK_EN
  logic [ADDR_W-1:0] win_word;
  logic              oob_rd_q;
  logic              err_q;

  assign win_word = win_addr >> 2;
  assign oob      = any_gnt && (win_word >= ADDR_W'(DEPTH));
  // An out-of-range read still completes, but with zero data.
  assign rd_word  = oob_rd_q ? '0 : bram_Do;
  assign err      = err_q;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      oob_rd_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      oob_rd_q <= oob && (win_we == 4'h0);
      if (oob) err_q <= 1'b1;
    end
  end
`else
  logic unused_depth;

  assign unused_depth = ^(ADDR_W'(DEPTH));
  assign oob          = 1'b0;
  assign rd_word      = bram_Do;
  assign err          = 1'b0;
`endif

  assign acc_en  = any_gnt & ~oob;
  assign bram_EN = acc_en;
  assign bram_WE = acc_en ? win_we : 4'h0;
  // Address/data keep their last driven value between grants.
  assign bram_A  = any_gnt ? win_addr  : a_q;
  assign bram_Di = any_gnt ? win_wdata : di_q;

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rvalid0_q ? rd_word : rhold0_q;
  assign m1_rdata  = rvalid1_q ? rd_word : rhold1_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (any_gnt && (state_q != ST_IDLE)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= MST1;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rhold0_q  <= '0;
      rhold1_q  <= '0;
      a_q       <= '0;
      di_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if (any_gnt) begin
        last_q <= gnt1 ? MST1 : MST0;
        a_q    <= win_addr;
        di_q   <= win_wdata;
      end
      rvalid0_q <= gnt0 && (m0_we == 4'h0);
      rvalid1_q <= gnt1 && (m1_we == 4'h0);
      if (rvalid0_q) rhold0_q <= rd_word;
      if (rvalid1_q) rhold1_q <= rd_word;
    end
  end

endmodule
